// File: rtl/regs_conf_pkg.sv
// Shared constants, command codes and sequencer state encoding for the
// configuration register chain; imported by the sequencer, register block and bench.
package regs_conf_pkg;

  localparam int NBYTES     = 11;
  localparam int BYTE_CNT_W = $clog2(NBYTES + 1);

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

  typedef logic [BYTE_CNT_W-1:0] byte_cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_RX    = 3'd1,
    ST_WR_LOAD  = 3'd2,
    ST_RD_LOAD  = 3'd3,
    ST_RD_SEND  = 3'd4,
    ST_RD_SHIFT = 3'd5,
    ST_RD_WAIT  = 3'd6
  } state_t;

endpackage

// File: rtl/regs_conf_timeout.sv
// Saturating inter-byte idle counter; o_expire marks the last permitted idle cycle.
module regs_conf_timeout #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/regs_conf_ctrl.sv
// Host-command sequencer for the 88-bit configuration chain: shifts written frames
// in from the UART receiver and paces readback bytes out to the UART transmitter.
module regs_conf_ctrl
  import regs_conf_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic       shift_rxregs,
  output logic       load_confregs,
  output logic       load_txregs,
  output logic       shift_txregs,
  output logic       busy,
  output logic       cfg_updated,
  output logic       err_cmd,
  output logic       err_timeout
);

  localparam byte_cnt_t LAST_BYTE = BYTE_CNT_W'(NBYTES - 1);

  state_t    r_state;
  state_t    w_state_nxt;
  byte_cnt_t r_byte_cnt;
  byte_cnt_t w_byte_cnt_nxt;
  logic      w_to_expire;

  // The idle counter restarts on every accepted byte and stays cleared outside WR_RX.
  regs_conf_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  ((r_state != ST_WR_RX) || rx_valid),
    .i_enable (r_state == ST_WR_RX),
    .o_expire (w_to_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    tx_start       = 1'b0;
    shift_rxregs   = 1'b0;
    load_confregs  = 1'b0;
    load_txregs    = 1'b0;
    shift_txregs   = 1'b0;
    cfg_updated    = 1'b0;
    err_cmd        = 1'b0;
    err_timeout    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WR) begin
            w_state_nxt    = ST_WR_RX;
            w_byte_cnt_nxt = '0;
          end else if (rx_data == CMD_RD) begin
            w_state_nxt = ST_RD_LOAD;
          end else begin
            err_cmd = 1'b1;
          end
        end
      end

      // A received byte takes priority over an expiring timeout in the same cycle.
      ST_WR_RX: begin
        if (rx_valid) begin
          shift_rxregs   = 1'b1;
          w_byte_cnt_nxt = r_byte_cnt + BYTE_CNT_W'(1);
          if (r_byte_cnt == LAST_BYTE) begin
            w_state_nxt = ST_WR_LOAD;
          end
        end else if (w_to_expire) begin
          err_timeout = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_WR_LOAD: begin
        load_confregs = 1'b1;
        cfg_updated   = 1'b1;
        w_state_nxt   = ST_IDLE;
      end

      ST_RD_LOAD: begin
        load_txregs    = 1'b1;
        w_byte_cnt_nxt = '0;
        w_state_nxt    = ST_RD_SEND;
      end

      ST_RD_SEND: begin
        if (tx_ready) begin
          tx_start    = 1'b1;
          w_state_nxt = ST_RD_SHIFT;
        end
      end

      // Shifting one cycle after tx_start lets the UART latch txdw first, and
      // skips the cycle in which tx_ready has not yet fallen.
      ST_RD_SHIFT: begin
        shift_txregs   = 1'b1;
        w_byte_cnt_nxt = r_byte_cnt + BYTE_CNT_W'(1);
        w_state_nxt    = (r_byte_cnt == LAST_BYTE) ? ST_IDLE : ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        if (tx_ready) begin
          w_state_nxt = ST_RD_SEND;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy = (r_state != ST_IDLE);

endmodule
